// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, multiply, iterative divide, data SRAM request
//
// Purpose:
//   Execute stage of the 5-stage in-order pipeline, between ID and MEM.
//   Holds one instruction from ID, computes its ALU / multiply / divide result,
//   issues the data SRAM request on the handoff cycle and packs the MEM bus.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   ms_allowin        MEM stage can accept
//   es_allowin        EXE stage can accept
//   ds_to_es_valid    ID has a valid instruction
//   ds_to_es_bus      decoded instruction bus from ID (DS_BUS_W bits)
//   es_to_ms_valid    valid to MEM
//   es_to_ms_bus      packed bus to MEM (MS_BUS_W bits)
//   data_sram_*       data SRAM request (enable, byte write enables, address, data)
//   es_fwd_bus        {write-back pending, load, dest, alu_result} for ID forwarding
//   out_es_valid      EXE holds a valid instruction
//   mem_ex            MEM holds an excepting instruction
//   wb_ex, wb_ertn    WB flush requests
//
// Optional build macro:
//   DIV_EARLY_OUT_EN  divider skips the 32 iterations when the divisor is zero
//                     or larger in magnitude than the dividend.

module exe_stage #(
  parameter int DS_BUS_W = 233,
  parameter int MS_BUS_W = 179
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ms_allowin,
  output logic                es_allowin,
  input  logic                ds_to_es_valid,
  input  logic [DS_BUS_W-1:0] ds_to_es_bus,
  output logic                es_to_ms_valid,
  output logic [MS_BUS_W-1:0] es_to_ms_bus,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  output logic [38:0]         es_fwd_bus,
  output logic                out_es_valid,
  input  logic                mem_ex,
  input  logic                wb_ex,
  input  logic                wb_ertn
);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // ---------------------------------------------------------------------------
  // Pipeline register
  // ---------------------------------------------------------------------------
  logic                es_valid_q, es_valid_d;
  logic [DS_BUS_W-1:0] es_bus_q, es_bus_d;
  logic                es_ready_go;
  logic                flush;

  logic        ds_has_int;
  logic [3:0]  exception_op;
  logic [33:0] csr_data;
  logic [4:0]  ld_op;
  logic [2:0]  st_op;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [11:0] alu_op;
  logic [6:0]  md_op;
  logic [31:0] alu_src1, alu_src2, rj_value, rkd_value, pc;

  assign {ds_has_int, exception_op, csr_data, ld_op, st_op, res_from_mem, gr_we,
          dest, alu_op, md_op, alu_src1, alu_src2, rj_value, rkd_value, pc} = es_bus_q;

  assign flush          = wb_ex || wb_ertn;
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign out_es_valid   = es_valid_q;

  always_comb begin
    es_valid_d = es_valid_q;
    es_bus_d   = es_bus_q;
    if (flush) begin
      es_valid_d = 1'b0;
    end else if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
    if (ds_to_es_valid && es_allowin) begin
      es_bus_d = ds_to_es_bus;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU (alu_op one-hot: add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui)
  // ---------------------------------------------------------------------------
  logic [31:0] alu_out;

  always_comb begin
    alu_out = 32'd0;
    if (alu_op[11]) alu_out = alu_out | (alu_src1 + alu_src2);
    if (alu_op[10]) alu_out = alu_out | (alu_src1 - alu_src2);
    if (alu_op[9])  alu_out = alu_out | {31'd0, $signed(alu_src1) < $signed(alu_src2)};
    if (alu_op[8])  alu_out = alu_out | {31'd0, alu_src1 < alu_src2};
    if (alu_op[7])  alu_out = alu_out | (alu_src1 & alu_src2);
    if (alu_op[6])  alu_out = alu_out | ~(alu_src1 | alu_src2);
    if (alu_op[5])  alu_out = alu_out | (alu_src1 | alu_src2);
    if (alu_op[4])  alu_out = alu_out | (alu_src1 ^ alu_src2);
    if (alu_op[3])  alu_out = alu_out | (alu_src1 << alu_src2[4:0]);
    if (alu_op[2])  alu_out = alu_out | (alu_src1 >> alu_src2[4:0]);
    if (alu_op[1])  alu_out = alu_out | $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
    if (alu_op[0])  alu_out = alu_out | alu_src2;
  end

  // ---------------------------------------------------------------------------
  // Multiplier: one 64-bit product serves all three ops. Operands are sign- or
  // zero-extended to 64 bits, so the truncated product is exact in both modes.
  // ---------------------------------------------------------------------------
  logic        mul_sgn;
  logic [63:0] mul_a, mul_b, mul_prod;

  assign mul_sgn  = md_op[6] | md_op[5];
  assign mul_a    = {{32{mul_sgn & alu_src1[31]}}, alu_src1};
  assign mul_b    = {{32{mul_sgn & alu_src2[31]}}, alu_src2};
  assign mul_prod = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Restoring divider on operand magnitudes
  // ---------------------------------------------------------------------------
  div_state_t  div_state_q, div_state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;

  logic        is_div, sdiv, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_shift, rem_diff;

  assign is_div = |md_op[3:0];
  assign sdiv   = md_op[3] | md_op[2];
  assign a_neg  = sdiv & alu_src1[31];
  assign b_neg  = sdiv & alu_src2[31];
  assign a_mag  = a_neg ? (32'd0 - alu_src1) : alu_src1;
  assign b_mag  = b_neg ? (32'd0 - alu_src2) : alu_src2;

  // quot_q doubles as the dividend shift register; a set borrow bit means the
  // trial subtraction failed and the shifted remainder is kept.
  assign rem_shift = {rem_q, quot_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};

`ifdef DIV_EARLY_OUT_EN
  logic early_out;
  assign early_out = (b_mag == 32'd0) || (b_mag > a_mag);
`endif

  always_comb begin
    div_state_d = div_state_q;
    cnt_d       = cnt_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dvsr_d      = dvsr_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (es_valid_q && is_div && !flush) begin
`ifdef DIV_EARLY_OUT_EN
          if (early_out) begin
            div_state_d = DIV_DONE;
            quot_d      = (b_mag == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
            rem_d       = a_mag;
          end else begin
            div_state_d = DIV_CALC;
            cnt_d       = 5'd0;
            quot_d      = a_mag;
            rem_d       = 32'd0;
            dvsr_d      = b_mag;
          end
`else
          div_state_d = DIV_CALC;
          cnt_d       = 5'd0;
          quot_d      = a_mag;
          rem_d       = 32'd0;
          dvsr_d      = b_mag;
`endif
        end
      end
      DIV_CALC: begin
        quot_d = {quot_q[30:0], ~rem_diff[32]};
        rem_d  = rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          div_state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (es_to_ms_valid && ms_allowin) begin
          div_state_d = DIV_IDLE;
        end
      end
      default: div_state_d = DIV_IDLE;
    endcase
    if (flush) begin
      div_state_d = DIV_IDLE;
    end
  end

  assign es_ready_go = !(es_valid_q && is_div && (div_state_q != DIV_DONE));

  // Sign correction: quotient takes sign(a)^sign(b), remainder takes sign(a).
  logic [31:0] div_q_res, div_r_res;
  assign div_q_res = (a_neg ^ b_neg) ? (32'd0 - quot_q) : quot_q;
  assign div_r_res = a_neg ? (32'd0 - rem_q) : rem_q;

  // ---------------------------------------------------------------------------
  // Result select
  // ---------------------------------------------------------------------------
  logic [31:0] md_res, alu_result;

  always_comb begin
    md_res = 32'd0;
    if (md_op[6])            md_res = mul_prod[31:0];
    if (md_op[5] | md_op[4]) md_res = mul_prod[63:32];
    if (md_op[3] | md_op[1]) md_res = div_q_res;
    if (md_op[2] | md_op[0]) md_res = div_r_res;
  end

  assign alu_result = (|md_op) ? md_res : alu_out;

  // ---------------------------------------------------------------------------
  // Store lane steering and SRAM request
  // ---------------------------------------------------------------------------
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic        kill, mem_op;

  always_comb begin
    st_we    = 4'b0000;
    st_wdata = rkd_value;
    if (st_op[2]) begin
      st_we    = 4'b0001 << alu_result[1:0];
      st_wdata = {4{rkd_value[7:0]}};
    end else if (st_op[1]) begin
      st_we    = alu_result[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{rkd_value[15:0]}};
    end else if (st_op[0]) begin
      st_we    = 4'b1111;
      st_wdata = rkd_value;
    end
  end

  // Any exception in flight (here, in MEM or in WB) suppresses the access so a
  // faulting store never reaches memory.
  assign kill   = mem_ex || wb_ex || wb_ertn || ds_has_int || (exception_op != 4'd0) || csr_data[29];
  assign mem_op = res_from_mem || (st_op != 3'd0);

  assign data_sram_en    = es_valid_q && es_ready_go && ms_allowin && mem_op && !kill;
  assign data_sram_we    = (es_valid_q && !kill) ? st_we : 4'b0000;
  assign data_sram_addr  = es_valid_q ? alu_result : 32'd0;
  assign data_sram_wdata = es_valid_q ? st_wdata : 32'd0;

  // ---------------------------------------------------------------------------
  // Output buses
  // ---------------------------------------------------------------------------
  assign es_to_ms_bus = {ds_has_int, exception_op, rj_value, rkd_value, csr_data, ld_op,
                         res_from_mem, gr_we, dest, alu_result, pc};
  assign es_fwd_bus   = {es_valid_q && gr_we, res_from_mem, dest, alu_result};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q  <= 1'b0;
      es_bus_q    <= '0;
      div_state_q <= DIV_IDLE;
      cnt_q       <= 5'd0;
      quot_q      <= 32'd0;
      rem_q       <= 32'd0;
      dvsr_q      <= 32'd0;
    end else begin
      es_valid_q  <= es_valid_d;
      es_bus_q    <= es_bus_d;
      div_state_q <= div_state_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard bench for exe_stage
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset, ms_allowin, ds_to_es_valid, mem_ex, wb_ex, wb_ertn;
  logic [232:0] ds_to_es_bus;
  logic         es_allowin, es_to_ms_valid, data_sram_en, out_es_valid;
  logic [178:0] es_to_ms_bus;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic [38:0]  es_fwd_bus;

  exe_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .es_fwd_bus(es_fwd_bus), .out_es_valid(out_es_valid),
    .mem_ex(mem_ex), .wb_ex(wb_ex), .wb_ertn(wb_ertn)
  );

  always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  localparam logic [11:0] OP_ADD = 12'h800;
  localparam logic [6:0] MD_MUL = 7'h40, MD_MULH = 7'h20, MD_MULHU = 7'h10,
                         MD_DIV = 7'h08, MD_MOD = 7'h04, MD_DIVU = 7'h02, MD_MODU = 7'h01;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] rkd;
    logic        en;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        cw;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_checks = 0, n_pass = 0;
  int en_pulses = 0, exp_pulses = 0;
  logic [31:0] pc_n = 32'h1c00_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [232:0] mk(input logic [11:0] aop, input logic [6:0] mop,
                                      input logic [2:0] sop, input logic rfm, input logic hint,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] rkd, input logic [31:0] pc);
    return {hint, 4'd0, 34'd0, 5'd0, sop, rfm, 1'b1, 5'd5, aop, mop, s1, s2, s1, rkd, pc};
  endfunction

  function automatic exp_t ex(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] rkd,
                              input logic en, input logic [3:0] we, input logic [31:0] wd,
                              input logic cw);
    exp_t e;
    e.pc = pc; e.res = res; e.rkd = rkd; e.en = en; e.we = we; e.wd = wd; e.cw = cw;
    return e;
  endfunction

  // Monitor: compares every handoff against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_sram_en) en_pulses++;
      if (es_to_ms_valid && ms_allowin) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_handoff: got pc 0x%08h expected no handoff", es_to_ms_bus[31:0]);
        end else begin
          mon_e = sb.pop_front();
          chk("result", es_to_ms_bus[63:32], mon_e.res);
          chk("pc", es_to_ms_bus[31:0], mon_e.pc);
          chk("rkd_pass", es_to_ms_bus[141:110], mon_e.rkd);
          chk("sram_en", {31'd0, data_sram_en}, {31'd0, mon_e.en});
          chk("sram_we", {28'd0, data_sram_we}, {28'd0, mon_e.we});
          if (mon_e.cw) chk("sram_wdata", data_sram_wdata, mon_e.wd);
        end
      end else if (!out_es_valid) begin
        chk("idle_sram_zero",
            {31'd0, (data_sram_en || data_sram_we != 4'd0 || data_sram_addr != 32'd0 || data_sram_wdata != 32'd0)},
            32'd0);
      end
    end
  end

  task automatic accept(input logic [232:0] bus, output bit ok);
    ds_to_es_bus   = bus;
    ds_to_es_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (es_allowin) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge clk); #1; end
    ds_to_es_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL accept_timeout: got es_allowin 0 expected 1");
    end
  endtask

  task automatic wait_out(input string name, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (es_to_ms_valid) begin seen = 1'b1; break; end
      if (out_es_valid) lat++;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s_timeout: got es_to_ms_valid 0 expected 1", name);
    end
  endtask

  task automatic run(input logic [232:0] bus, input exp_t e, input string name, output int lat);
    bit ok;
    accept(bus, ok);
    lat = -1;
    if (ok) begin
      sb.push_back(e);
      if (e.en) exp_pulses++;
      wait_out(name, lat);
      @(posedge clk); #1;
    end
    pc_n = pc_n + 32'd4;
  endtask

  // ALU vectors: {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
  logic [11:0] a_op [12] = '{12'h800, 12'h400, 12'h200, 12'h100, 12'h080, 12'h040,
                             12'h020, 12'h010, 12'h008, 12'h004, 12'h002, 12'h001};
  logic [31:0] a_s1 [12] = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0,
                             32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] a_s2 [12] = '{32'h1, 32'h7, 32'h1, 32'h1, 32'h0FF00FF0, 32'h0FF00FF0,
                             32'h0FF00FF0, 32'h0FF00FF0, 32'h21, 32'h4, 32'h4, 32'h12345000};
  logic [31:0] a_ex [12] = '{32'h80000000, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h00F000F0, 32'h000F000F,
                             32'hFFF0FFF0, 32'hFF00FF00, 32'h2, 32'h08000000, 32'hF8000000, 32'h12345000};

  // Multiply / divide vectors
  logic [6:0]  m_op [15] = '{MD_MUL, MD_MULH, MD_MULHU, MD_MULH, MD_MOD, MD_DIVU, MD_MODU, MD_DIV,
                             MD_MOD, MD_DIV, MD_MOD, MD_DIV, MD_MOD, MD_DIVU, MD_MUL};
  logic [31:0] m_s1 [15] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFF9, 32'h5, 32'h5,
                             32'h80000000, 32'h80000000, 32'h7, 32'h7, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'hFFFFFFFF, 32'h12345678};
  logic [31:0] m_s2 [15] = '{32'h2, 32'h2, 32'h2, 32'h7FFFFFFF, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h3, 32'h10};
  logic [31:0] m_ex [15] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1, 32'h3FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5,
                             32'h80000000, 32'h0, 32'hFFFFFFFD, 32'h1, 32'h1, 32'hFFFFFFF9,
                             32'h55555555, 32'h23456780};

  // Memory vectors: st_op, load, int, base, offset, rkd, en, we, wdata, check wdata
  logic [2:0]  s_op [6]  = '{3'b100, 3'b010, 3'b010, 3'b100, 3'b000, 3'b000};
  logic        s_ld [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        s_in [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] s_s1 [6]  = '{32'h1000, 32'h2000, 32'h2000, 32'h1000, 32'h4000, 32'h4000};
  logic [31:0] s_s2 [6]  = '{32'h3, 32'h2, 32'h0, 32'h1, 32'h4, 32'h8};
  logic [31:0] s_rk [6]  = '{32'hAB, 32'h1234, 32'h5678, 32'hCD, 32'h0, 32'h0};
  logic        s_en [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0]  s_we [6]  = '{4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b0000, 4'b0000};
  logic [31:0] s_wd [6]  = '{32'hABABABAB, 32'h12341234, 32'h56785678, 32'hCDCDCDCD, 32'h0, 32'h0};
  logic        s_cw [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  ok;
    reset = 1'b1; ms_allowin = 1'b1; mem_ex = 1'b0; wb_ex = 1'b0; wb_ertn = 1'b0;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(OP_ADD, 7'd0, 3'b001, 1'b0, 1'b0, 32'h100, 32'h0, 32'h55, pc_n);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("reset_es_valid", {31'd0, out_es_valid}, 32'd0);
    chk("reset_to_ms_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("reset_allowin", {31'd0, es_allowin}, 32'd1);
    chk("reset_sram_we", {28'd0, data_sram_we}, 32'd0);
    @(posedge clk); #1;

    // ALU, result one cycle after acceptance
    for (int i = 0; i < 12; i++) begin
      run(mk(a_op[i], 7'd0, 3'd0, 1'b0, 1'b0, a_s1[i], a_s2[i], a_s2[i], pc_n),
          ex(pc_n, a_ex[i], a_s2[i], 1'b0, 4'd0, 32'd0, 1'b0), "alu", lat);
      if (i == 0) chk("add_latency", lat, 32'd0);
    end

    // Divide latency, then multiply/divide table
    run(mk(12'd0, MD_DIV, 3'd0, 1'b0, 1'b0, 32'hFFFFFFF9, 32'h2, 32'h2, pc_n),
        ex(pc_n, 32'hFFFFFFFD, 32'h2, 1'b0, 4'd0, 32'd0, 1'b0), "div", lat);
    chk("div_latency", lat, 32'd33);
    for (int i = 0; i < 15; i++) begin
      run(mk(12'd0, m_op[i], 3'd0, 1'b0, 1'b0, m_s1[i], m_s2[i], m_s2[i], pc_n),
          ex(pc_n, m_ex[i], m_s2[i], 1'b0, 4'd0, 32'd0, 1'b0), "md", lat);
    end

    // Small-dividend divide (early out when enabled)
    run(mk(12'd0, MD_DIVU, 3'd0, 1'b0, 1'b0, 32'd3, 32'd10, 32'd10, pc_n),
        ex(pc_n, 32'd0, 32'd10, 1'b0, 4'd0, 32'd0, 1'b0), "divu_small", lat);
    chk("divu_small_latency", lat, EARLY_LAT);
    run(mk(12'd0, MD_MODU, 3'd0, 1'b0, 1'b0, 32'd3, 32'd10, 32'd10, pc_n),
        ex(pc_n, 32'd3, 32'd10, 1'b0, 4'd0, 32'd0, 1'b0), "modu_small", lat);
    chk("modu_small_latency", lat, EARLY_LAT);

    // Loads and stores
    for (int i = 0; i < 6; i++) begin
      run(mk(OP_ADD, 7'd0, s_op[i], s_ld[i], s_in[i], s_s1[i], s_s2[i], s_rk[i], pc_n),
          ex(pc_n, s_s1[i] + s_s2[i], s_rk[i], s_en[i], s_we[i], s_wd[i], s_cw[i]), "mem", lat);
    end
    mem_ex = 1'b1;
    run(mk(OP_ADD, 7'd0, 3'b100, 1'b0, 1'b0, 32'h1000, 32'h3, 32'hAB, pc_n),
        ex(pc_n, 32'h1003, 32'hAB, 1'b0, 4'd0, 32'd0, 1'b0), "st_mem_ex", lat);
    mem_ex = 1'b0;

    // Flush in the middle of a divide, then a fresh divide
    accept(mk(12'd0, MD_DIV, 3'd0, 1'b0, 1'b0, 32'd100, 32'd7, 32'd7, pc_n), ok);
    repeat (11) @(posedge clk);
    #1 wb_ex = 1'b1;
    @(posedge clk);
    #1 wb_ex = 1'b0;
    @(negedge clk);
    chk("flush_es_valid", {31'd0, out_es_valid}, 32'd0);
    chk("flush_allowin", {31'd0, es_allowin}, 32'd1);
    @(posedge clk); #1;
    pc_n = pc_n + 32'd4;
    run(mk(12'd0, MD_DIV, 3'd0, 1'b0, 1'b0, 32'd100, 32'd7, 32'd7, pc_n),
        ex(pc_n, 32'd14, 32'd7, 1'b0, 4'd0, 32'd0, 1'b0), "div_after_flush", lat);
    chk("div_after_flush_latency", lat, 32'd33);
    run(mk(12'd0, MD_MOD, 3'd0, 1'b0, 1'b0, 32'd100, 32'd7, 32'd7, pc_n),
        ex(pc_n, 32'd2, 32'd7, 1'b0, 4'd0, 32'd0, 1'b0), "mod_after_flush", lat);

    // MEM back-pressure while the divider holds its result
    ms_allowin = 1'b0;
    run(mk(12'd0, MD_DIVU, 3'd0, 1'b0, 1'b0, 32'd100, 32'd7, 32'd7, pc_n),
        ex(pc_n, 32'd14, 32'd7, 1'b0, 4'd0, 32'd0, 1'b0), "div_stall", lat);
    chk("div_stall_latency", lat, 32'd33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("div_stall_valid", {31'd0, es_to_ms_valid}, 32'd1);
      chk("div_stall_result", es_to_ms_bus[63:32], 32'd14);
    end
    @(posedge clk);
    #1 ms_allowin = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    // MEM back-pressure on a store: exactly one request on the handoff
    ms_allowin = 1'b0;
    run(mk(OP_ADD, 7'd0, 3'b001, 1'b0, 1'b0, 32'h3000, 32'h0, 32'hDEADBEEF, pc_n),
        ex(pc_n, 32'h3000, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b1), "st_stall", lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_stall_no_en", {31'd0, data_sram_en}, 32'd0);
    end
    @(posedge clk);
    #1 ms_allowin = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    repeat (2) @(posedge clk);
    #1;
    chk("sram_en_pulses", en_pulses, exp_pulses);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
